// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the queue entry type for the fetch front end.
// PC width follows DWORD_BITS when the build defines it, 64 otherwise.
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

package fetch_pkg;

  localparam int INSTR_BITS = 32;
  localparam int PC_BITS    = `DWORD_BITS;

  localparam logic [PC_BITS-1:0] PC_STEP = PC_BITS'(4);

  typedef struct packed {
    logic [PC_BITS-1:0]    pc;
    logic [INSTR_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc, instr} with clear and a combinational head.
// The head reads as all-zero while the queue is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset || clear)
    !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || clear)
    !(pop && count == '0));

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: owns the fetch PC, issues in-order imem requests, buffers for decode.
// Define IPQ_PERF_EN to add the perf_fetched / perf_flushed counters.
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [PC_BITS-1:0]    redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_BITS-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_BITS-1:0] imem_rsp_instr,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [PC_BITS-1:0]    dec_pc,
  output logic [INSTR_BITS-1:0] dec_instr
`ifdef IPQ_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`endif
);

  localparam int             CW  = $clog2(DEPTH+1);
  localparam logic [CW:0]    CAP = (CW+1)'(DEPTH);

  logic [PC_BITS-1:0] fetch_pc;
  logic [PC_BITS-1:0] rsp_pc;
  logic [PC_BITS-1:0] redir_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop;
  logic [CW-1:0]      count;
  logic [CW:0]        inflight;
  logic               req_fire;
  logic               push;
  logic               pop;
  logic               rsp_drop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  assign redir_pc = redirect_pc & ~PC_BITS'(3);
  assign inflight = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid = !reset && !redirect_valid
                        && (inflight < CAP) && (drop == '0);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign push     = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign pop      = dec_valid && dec_ready && !redirect_valid;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  // Every request still in flight at a redirect belongs to the old stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop        <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (push)     rsp_pc   <= rsp_pc + PC_STEP;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) drop <= drop - CW'(1);
    end
  end

`ifdef IPQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid)
        perf_flushed <= perf_flushed + 32'(count) + 32'(imem_rsp_valid);
      else if (rsp_drop)
        perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

  a_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && outstanding == '0));
  a_credit: assert property (@(posedge clk) disable iff (reset)
    inflight <= CAP);
  a_drop_bound: assert property (@(posedge clk) disable iff (reset)
    drop <= outstanding);

endmodule
